// File: rtl/audio_pkg.sv
// Shared definitions for the audio sequencer: state encoding, sample layout and
// the sample-to-SRAM-word mapping (sample n lives at words 2n and 2n+1).
package audio_pkg;

  localparam int STATE_W  = 3;
  localparam int CHAN_W   = 16;
  localparam int SAMPLE_W = 2 * CHAN_W;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_REC_REQ   = 3'd1,
    ST_REC_WR_L  = 3'd2,
    ST_REC_WR_R  = 3'd3,
    ST_PLAY_RD_L = 3'd4,
    ST_PLAY_RD_R = 3'd5,
    ST_PLAY_OUT  = 3'd6,
    ST_PAUSED    = 3'd7
  } state_t;

  // Word-address LSB selecting the channel half of a sample.
  localparam logic WORD_LEFT  = 1'b0;
  localparam logic WORD_RIGHT = 1'b1;

  function automatic logic [CHAN_W-1:0] chan_sel(input logic [SAMPLE_W-1:0] sample,
                                                 input logic half);
    return (half == WORD_RIGHT) ? sample[CHAN_W-1:0] : sample[SAMPLE_W-1:CHAN_W];
  endfunction

endpackage

// File: rtl/sram_port_mux.sv
// Drives the SRAM address, write data and active-low strobes straight from the
// sequencer state and its sample counters.
module sram_port_mux
  import audio_pkg::*;
#(
  parameter int ADDR_W = 20
) (
  input  logic [STATE_W-1:0]  state_i,
  input  logic [ADDR_W-2:0]   rec_len_i,
  input  logic [ADDR_W-2:0]   play_pos_i,
  input  logic [SAMPLE_W-1:0] rec_data_i,
  output logic [ADDR_W-1:0]   sram_addr_o,
  output logic [CHAN_W-1:0]   sram_wdata_o,
  output logic                sram_we_n_o,
  output logic                sram_oe_n_o
);

  logic              is_wr;
  logic              is_rd;
  logic              half;
  logic [ADDR_W-2:0] pos;

  always_comb begin
    is_wr = (state_i == ST_REC_WR_L) || (state_i == ST_REC_WR_R);
    is_rd = (state_i == ST_PLAY_RD_L) || (state_i == ST_PLAY_RD_R);
    half  = ((state_i == ST_REC_WR_R) || (state_i == ST_PLAY_RD_R)) ? WORD_RIGHT : WORD_LEFT;
    pos   = is_rd ? play_pos_i : rec_len_i;
  end

  assign sram_addr_o  = (is_wr || is_rd) ? {pos, half} : '0;
  assign sram_wdata_o = chan_sel(rec_data_i, half);
  assign sram_we_n_o  = ~is_wr;
  assign sram_oe_n_o  = ~is_rd;

endmodule

// File: rtl/audio_sequencer.sv
// Record/playback sequencer moving stereo samples between an audio bus and a
// 16-bit asynchronous SRAM, with stop/pause handled at sample boundaries.
module audio_sequencer
  import audio_pkg::*;
#(
  parameter int ADDR_W = 20
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rec,
  input  logic              i_play,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_loop,
  output logic              o_record_ready,
  input  logic              i_record_valid,
  input  logic [31:0]       i_record_data,
  output logic              o_play_valid,
  output logic [31:0]       o_play_data,
  input  logic              i_play_ready,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [15:0]       o_sram_wdata,
  input  logic [15:0]       i_sram_rdata,
  output logic              o_sram_we_n,
  output logic              o_sram_oe_n,
  output logic [2:0]        o_state,
  output logic              o_paused,
  output logic              o_full,
  output logic [ADDR_W-2:0] o_rec_len,
  output logic [ADDR_W-2:0] o_play_pos
);

  localparam int LEN_W = ADDR_W - 1;

  state_t              state_q, state_d, resume_q, resume_d;
  logic [LEN_W-1:0]    rec_len_q, rec_len_d, play_pos_q, play_pos_d, play_pos_inc;
  logic                full_q, full_d;
  logic                pend_stop_q, pend_stop_d, pend_pause_q, pend_pause_d;
  logic [SAMPLE_W-1:0] rec_data_q, rec_data_d, play_data_q, play_data_d;
  logic                record_ready_q, play_valid_q, paused_q;
  logic                stop_now, pause_now;

  assign play_pos_inc = play_pos_q + 1'b1;
  assign stop_now     = pend_stop_q | i_stop;
  assign pause_now    = pend_pause_q | i_pause;

  // A full memory wraps rec_len to 0; o_full marks it as 2^(ADDR_W-1) samples,
  // and the modular play_pos compare then ends playback after the last sample.
  always_comb begin
    state_d      = state_q;
    resume_d     = resume_q;
    rec_len_d    = rec_len_q;
    play_pos_d   = play_pos_q;
    full_d       = full_q;
    pend_stop_d  = pend_stop_q;
    pend_pause_d = pend_pause_q;
    rec_data_d   = rec_data_q;
    play_data_d  = play_data_q;
    case (state_q)
      ST_IDLE: begin
        if (!i_stop && !i_pause) begin
          if (i_rec) begin
            rec_len_d = '0;
            full_d    = 1'b0;
            state_d   = ST_REC_REQ;
          end else if (i_play && ((rec_len_q != '0) || full_q)) begin
            play_pos_d = '0;
            state_d    = ST_PLAY_RD_L;
          end
        end
      end
      ST_REC_REQ: begin
        if (i_stop) begin
          state_d = ST_IDLE;
        end else if (i_pause) begin
          resume_d = ST_REC_REQ;
          state_d  = ST_PAUSED;
        end else if (i_record_valid) begin
          rec_data_d = i_record_data;
          state_d    = ST_REC_WR_L;
        end
      end
      ST_REC_WR_L: begin
        pend_stop_d  = stop_now;
        pend_pause_d = pause_now;
        state_d      = ST_REC_WR_R;
      end
      ST_REC_WR_R: begin
        rec_len_d    = rec_len_q + 1'b1;
        pend_stop_d  = 1'b0;
        pend_pause_d = 1'b0;
        if (&rec_len_q) begin
          full_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (stop_now) begin
          state_d = ST_IDLE;
        end else if (pause_now) begin
          resume_d = ST_REC_REQ;
          state_d  = ST_PAUSED;
        end else begin
          state_d = ST_REC_REQ;
        end
      end
      ST_PLAY_RD_L: begin
        play_data_d  = {i_sram_rdata, play_data_q[CHAN_W-1:0]};
        pend_stop_d  = stop_now;
        pend_pause_d = pause_now;
        state_d      = ST_PLAY_RD_R;
      end
      ST_PLAY_RD_R: begin
        play_data_d  = {play_data_q[SAMPLE_W-1:CHAN_W], i_sram_rdata};
        pend_stop_d  = stop_now;
        pend_pause_d = pause_now;
        state_d      = ST_PLAY_OUT;
      end
      ST_PLAY_OUT: begin
        if (i_play_ready) begin
          play_pos_d   = play_pos_inc;
          pend_stop_d  = 1'b0;
          pend_pause_d = 1'b0;
          if ((play_pos_inc == rec_len_q) && !i_loop) begin
            state_d = ST_IDLE;
          end else begin
            if (play_pos_inc == rec_len_q) play_pos_d = '0;
            if (stop_now) begin
              state_d = ST_IDLE;
            end else if (pause_now) begin
              resume_d = ST_PLAY_RD_L;
              state_d  = ST_PAUSED;
            end else begin
              state_d = ST_PLAY_RD_L;
            end
          end
        end else begin
          pend_stop_d  = stop_now;
          pend_pause_d = pause_now;
        end
      end
      ST_PAUSED: begin
        if (i_stop)       state_d = ST_IDLE;
        else if (i_pause) state_d = resume_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q        <= ST_IDLE;
      resume_q       <= ST_IDLE;
      rec_len_q      <= '0;
      play_pos_q     <= '0;
      full_q         <= 1'b0;
      pend_stop_q    <= 1'b0;
      pend_pause_q   <= 1'b0;
      rec_data_q     <= '0;
      play_data_q    <= '0;
      record_ready_q <= 1'b0;
      play_valid_q   <= 1'b0;
      paused_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      resume_q       <= resume_d;
      rec_len_q      <= rec_len_d;
      play_pos_q     <= play_pos_d;
      full_q         <= full_d;
      pend_stop_q    <= pend_stop_d;
      pend_pause_q   <= pend_pause_d;
      rec_data_q     <= rec_data_d;
      play_data_q    <= play_data_d;
      record_ready_q <= (state_d == ST_REC_REQ);
      play_valid_q   <= (state_d == ST_PLAY_OUT);
      paused_q       <= (state_d == ST_PAUSED);
    end
  end

  sram_port_mux #(.ADDR_W(ADDR_W)) u_sram_port_mux (
    .state_i      (state_q),
    .rec_len_i    (rec_len_q),
    .play_pos_i   (play_pos_q),
    .rec_data_i   (rec_data_q),
    .sram_addr_o  (o_sram_addr),
    .sram_wdata_o (o_sram_wdata),
    .sram_we_n_o  (o_sram_we_n),
    .sram_oe_n_o  (o_sram_oe_n)
  );

  assign o_state        = state_q;
  assign o_record_ready = record_ready_q;
  assign o_play_valid   = play_valid_q;
  assign o_play_data    = play_data_q;
  assign o_paused       = paused_q;
  assign o_full         = full_q;
  assign o_rec_len      = rec_len_q;
  assign o_play_pos     = play_pos_q;

endmodule

// File: tb/tb_audio_sequencer.sv
// Bench for audio_sequencer: behavioural SRAM, audio-bus driver/consumer and a
// queue of expected playback samples filled from what was recorded.
module tb_audio_sequencer;
  import audio_pkg::*;

  localparam int AW = 4;
  localparam int LW = AW - 1;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_rec = 1'b0, i_play = 1'b0, i_pause = 1'b0, i_stop = 1'b0, i_loop = 1'b0;
  logic          o_record_ready;
  logic          i_record_valid = 1'b0;
  logic [31:0]   i_record_data = '0;
  logic          o_play_valid;
  logic [31:0]   o_play_data;
  logic          i_play_ready = 1'b0;
  logic [AW-1:0] o_sram_addr;
  logic [15:0]   o_sram_wdata, i_sram_rdata;
  logic          o_sram_we_n, o_sram_oe_n;
  logic [2:0]    o_state;
  logic          o_paused, o_full;
  logic [LW-1:0] o_rec_len, o_play_pos;

  logic [15:0] mem [0:(1<<AW)-1];
  logic [31:0] rec_model [$];
  logic [31:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) if (!o_sram_we_n) mem[o_sram_addr] <= o_sram_wdata;
  assign i_sram_rdata = o_sram_oe_n ? 16'h0000 : mem[o_sram_addr];

  audio_sequencer #(.ADDR_W(AW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rec(i_rec), .i_play(i_play), .i_pause(i_pause),
    .i_stop(i_stop), .i_loop(i_loop), .o_record_ready(o_record_ready),
    .i_record_valid(i_record_valid), .i_record_data(i_record_data),
    .o_play_valid(o_play_valid), .o_play_data(o_play_data), .i_play_ready(i_play_ready),
    .o_sram_addr(o_sram_addr), .o_sram_wdata(o_sram_wdata), .i_sram_rdata(i_sram_rdata),
    .o_sram_we_n(o_sram_we_n), .o_sram_oe_n(o_sram_oe_n), .o_state(o_state),
    .o_paused(o_paused), .o_full(o_full), .o_rec_len(o_rec_len), .o_play_pos(o_play_pos)
  );

  // m = {stop, pause, rec, play}, held for exactly one rising edge
  task automatic pulse(input logic [3:0] m);
    @(negedge i_clk);
    {i_stop, i_pause, i_rec, i_play} = m;
    @(negedge i_clk);
    {i_stop, i_pause, i_rec, i_play} = 4'b0000;
  endtask

  task automatic wait_state(input logic [2:0] st, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge i_clk);
      if (o_state == st) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge i_clk);
      if (o_play_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic record_sample(input logic [31:0] data, input bit stop_in_wr,
                               output bit ok, output logic [2:0] st_at_stop);
    ok = 1'b0;
    st_at_stop = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge i_clk);
      if (o_record_ready) begin ok = 1'b1; break; end
    end
    if (ok) begin
      i_record_valid = 1'b1;
      i_record_data  = data;
      @(negedge i_clk);
      i_record_valid = 1'b0;
      rec_model.push_back(data);
      $display("record sample %h", data);
      if (stop_in_wr) begin
        st_at_stop = o_state;
        i_stop = 1'b1;
        @(negedge i_clk);
        i_stop = 1'b0;
      end
    end
  endtask

  task automatic consume(output logic [31:0] obs, output logic [31:0] expv, output bit ok);
    obs = '0;
    expv = '0;
    wait_valid(ok);
    if (ok) begin
      obs  = o_play_data;
      expv = (exp_q.size() > 0) ? exp_q.pop_front() : ~obs;
      $display("play sample %h expected %h", obs, expv);
      i_play_ready = 1'b1;
      @(negedge i_clk);
      i_play_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge i_clk);
    checks++;
    if ({o_state, o_record_ready, o_play_valid, o_sram_we_n, o_sram_oe_n, o_full, o_paused}
        !== {3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_flags got st=%0d rr=%b pv=%b we=%b oe=%b full=%b pau=%b required 0 0 0 1 1 0 0",
               o_state, o_record_ready, o_play_valid, o_sram_we_n, o_sram_oe_n, o_full, o_paused);
    end
    checks++;
    if (o_rec_len !== '0 || o_play_pos !== '0 || o_play_data !== '0) begin
      errors++;
      $display("FAIL reset_counters got len=%0d pos=%0d data=%h required 0 0 0",
               o_rec_len, o_play_pos, o_play_data);
    end
    i_rst = 1'b0;
  endtask

  task automatic test_record();
    logic [15:0] w [6];
    logic [31:0] s [3];
    logic [2:0] st;
    bit ok;
    w = '{16'hAAAA, 16'h5555, 16'h1234, 16'h5678, 16'hFFFF, 16'h0000};
    s = '{32'hAAAA5555, 32'h12345678, 32'hFFFF0000};
    rec_model.delete();
    pulse(4'b0010);
    for (int k = 0; k < 3; k++) begin
      record_sample(s[k], 1'b0, ok, st);
      checks++;
      if (!ok) begin errors++; $display("FAIL record_ready[%0d] got timeout required ready", k); end
    end
    pulse(4'b1000);
    wait_state(ST_IDLE, ok);
    checks++;
    if (!ok || o_rec_len !== 3'd3) begin
      errors++;
      $display("FAIL record_len got state=%0d len=%0d required IDLE len=3", o_state, o_rec_len);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (mem[k] !== w[k]) begin
        errors++;
        $display("FAIL sram_word[%0d] got %h required %h", k, mem[k], w[k]);
      end
    end
  endtask

  task automatic test_play_noloop();
    logic [31:0] obs, expv;
    bit ok;
    i_loop = 1'b0;
    foreach (rec_model[k]) exp_q.push_back(rec_model[k]);
    pulse(4'b0001);
    for (int k = 0; k < 3; k++) begin
      consume(obs, expv, ok);
      checks++;
      if (!ok || obs !== expv) begin
        errors++;
        $display("FAIL play_noloop[%0d] got %h (valid seen %0d) required %h", k, obs, ok, expv);
      end
    end
    wait_state(ST_IDLE, ok);
    checks++;
    if (!ok || o_play_pos !== 3'd3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL play_noloop_end got state=%0d pos=%0d left=%0d required IDLE pos=3 left=0",
               o_state, o_play_pos, exp_q.size());
    end
  endtask

  task automatic test_play_loop();
    logic [31:0] obs, expv;
    bit ok;
    i_loop = 1'b1;
    foreach (rec_model[k]) exp_q.push_back(rec_model[k]);
    exp_q.push_back(rec_model[0]);
    pulse(4'b0001);
    for (int k = 0; k < 6; k++) begin
      if (k == 4) begin
        i_loop = 1'b0;
        exp_q.push_back(rec_model[1]);
        exp_q.push_back(rec_model[2]);
      end
      consume(obs, expv, ok);
      checks++;
      if (!ok || obs !== expv) begin
        errors++;
        $display("FAIL play_loop[%0d] got %h (valid seen %0d) required %h", k, obs, ok, expv);
      end
    end
    wait_state(ST_IDLE, ok);
    checks++;
    if (!ok || o_play_pos !== 3'd3) begin
      errors++;
      $display("FAIL play_loop_end got state=%0d pos=%0d required IDLE pos=3", o_state, o_play_pos);
    end
  endtask

  task automatic test_pause_play();
    logic [31:0] obs, expv;
    bit ok;
    i_loop = 1'b0;
    foreach (rec_model[k]) exp_q.push_back(rec_model[k]);
    pulse(4'b0001);
    consume(obs, expv, ok);
    checks++;
    if (!ok || obs !== expv) begin
      errors++; $display("FAIL pause_first got %h required %h", obs, expv);
    end
    wait_valid(ok);
    pulse(4'b0100);
    checks++;
    if (!ok || o_state !== ST_PLAY_OUT || !o_play_valid) begin
      errors++;
      $display("FAIL pause_held got state=%0d valid=%b required PLAY_OUT valid=1", o_state, o_play_valid);
    end
    consume(obs, expv, ok);
    checks++;
    if (!ok || obs !== expv) begin
      errors++; $display("FAIL pause_delivered got %h required %h", obs, expv);
    end
    wait_state(ST_PAUSED, ok);
    repeat (3) @(negedge i_clk);
    checks++;
    if (!ok || o_state !== ST_PAUSED || !o_paused || o_play_valid || o_play_pos !== 3'd2) begin
      errors++;
      $display("FAIL paused got state=%0d paused=%b valid=%b pos=%0d required PAUSED 1 0 2",
               o_state, o_paused, o_play_valid, o_play_pos);
    end
    pulse(4'b0100);
    consume(obs, expv, ok);
    checks++;
    if (!ok || obs !== expv) begin
      errors++; $display("FAIL pause_resume got %h required %h", obs, expv);
    end
    wait_state(ST_IDLE, ok);
    checks++;
    if (!ok || o_paused || exp_q.size() != 0) begin
      errors++; $display("FAIL pause_end got state=%0d paused=%b required IDLE 0", o_state, o_paused);
    end
  endtask

  task automatic test_stop_in_write();
    logic [2:0] st;
    bit ok;
    rec_model.delete();
    pulse(4'b0010);
    record_sample(32'hCAFEBABE, 1'b1, ok, st);
    checks++;
    if (!ok || st !== ST_REC_WR_L) begin
      errors++; $display("FAIL stop_timing got state=%0d required REC_WR_L", st);
    end
    wait_state(ST_IDLE, ok);
    checks++;
    if (!ok || o_rec_len !== 3'd1 || mem[0] !== 16'hCAFE || mem[1] !== 16'hBABE) begin
      errors++;
      $display("FAIL stop_in_write got state=%0d len=%0d w0=%h w1=%h required IDLE 1 CAFE BABE",
               o_state, o_rec_len, mem[0], mem[1]);
    end
  endtask

  task automatic test_full();
    logic [31:0] obs, expv;
    logic [2:0] st;
    bit ok;
    rec_model.delete();
    pulse(4'b0010);
    for (int k = 0; k < 8; k++) begin
      record_sample(32'(32'h0101_0101 * (k + 1)) ^ 32'h8000_0001, 1'b0, ok, st);
      checks++;
      if (!ok) begin errors++; $display("FAIL full_record[%0d] got timeout required ready", k); end
    end
    wait_state(ST_IDLE, ok);
    checks++;
    if (!ok || !o_full) begin
      errors++; $display("FAIL full_flag got state=%0d full=%b required IDLE 1", o_state, o_full);
    end
    pulse(4'b1010);
    repeat (3) @(negedge i_clk);
    checks++;
    if (o_state !== ST_IDLE || !o_full || o_record_ready) begin
      errors++;
      $display("FAIL rec_stop_same_cycle got state=%0d full=%b ready=%b required IDLE 1 0",
               o_state, o_full, o_record_ready);
    end
    i_loop = 1'b0;
    foreach (rec_model[k]) exp_q.push_back(rec_model[k]);
    pulse(4'b0001);
    for (int k = 0; k < 8; k++) begin
      consume(obs, expv, ok);
      checks++;
      if (!ok || obs !== expv) begin
        errors++; $display("FAIL full_play[%0d] got %h required %h", k, obs, expv);
      end
    end
    wait_state(ST_IDLE, ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      errors++; $display("FAIL full_play_end got state=%0d required IDLE", o_state);
    end
  endtask

  task automatic test_reset_in_play();
    bit ok;
    bit moved;
    foreach (rec_model[k]) exp_q.push_back(rec_model[k]);
    pulse(4'b0001);
    wait_valid(ok);
    #2 i_rst = 1'b1;
    #1;
    checks++;
    if (!ok || o_play_valid || o_state !== ST_IDLE || o_rec_len !== '0 || o_full) begin
      errors++;
      $display("FAIL reset_in_play got valid=%b state=%0d len=%0d full=%b required 0 IDLE 0 0",
               o_play_valid, o_state, o_rec_len, o_full);
    end
    exp_q.delete();
    @(negedge i_clk);
    i_rst = 1'b0;
    pulse(4'b0001);
    moved = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      if (o_state !== ST_IDLE || !o_sram_oe_n) moved = 1'b1;
    end
    checks++;
    if (moved) begin
      errors++; $display("FAIL play_after_reset got state=%0d oe_n=%b required IDLE 1", o_state, o_sram_oe_n);
    end
  endtask

  initial begin
    test_reset();
    test_record();
    test_play_noloop();
    test_play_loop();
    test_pause_play();
    test_stop_in_write();
    test_full();
    test_reset_in_play();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
